// File: rtl/golden_nonce_tx.sv
// Golden-nonce reporter: queues 32-bit nonces in a small FIFO and sends each one
// as a 6-byte 8N1 UART frame (A5, nonce MSB..LSB, XOR checksum).
module golden_nonce_tx #(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 12000000,
  parameter int fifo_depth   = 4
) (
  input  logic                          comm_clk,
  input  logic                          reset,
  input  logic                          nonce_valid,
  input  logic [31:0]                   nonce,
  output logic                          tx_serial,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
  localparam int PTR_W        = $clog2(fifo_depth);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BCNT_W       = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [47:0]       frame_q, frame_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [31:0]       mem_q [fifo_depth];
  logic [31:0]       head;
  logic [7:0]        head_chk;
  logic              push;
  logic              pop;
  logic              bit_last;

  assign head     = mem_q[rd_ptr_q];
  assign head_chk = head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
  assign bit_last = (bit_cnt_q == BCNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    tx_d       = 1'b1;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          frame_d    = {8'hA5, head, head_chk};
          byte_idx_d = 3'd0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      DATA: begin
        // The byte on the wire always sits in the top octet of the frame register.
        tx_d = frame_q[40 + int'(bit_idx_q)];
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (byte_idx_q != 3'd5) begin
            byte_idx_d = byte_idx_q + 3'd1;
            frame_d    = {frame_q[39:0], 8'h00};
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a push when the head leaves on the same edge.
    push       = nonce_valid && ((count_q < CNT_W'(fifo_depth)) || pop);
    overflow_d = overflow_q || (nonce_valid && !push);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge comm_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= nonce;
    end
  end

  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_serial  = tx_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Scoreboard bench for golden_nonce_tx: expected frame bytes are queued at push time
// and compared against bytes decoded from the UART line.
module tb_golden_nonce_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        tx_serial, busy, overflow;
  logic [2:0]  fifo_count;

  logic        nonce_valid_real;
  logic [31:0] nonce_real;
  logic        tx_real, busy_real, overflow_real;
  logic [2:0]  count_real;

  always #5 clk = ~clk;

  golden_nonce_tx #(.baud_rate(1), .sys_clk_freq(4), .fifo_depth(4)) dut (
    .comm_clk(clk), .reset(reset), .nonce_valid(nonce_valid), .nonce(nonce),
    .tx_serial(tx_serial), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  golden_nonce_tx u_real (
    .comm_clk(clk), .reset(reset), .nonce_valid(nonce_valid_real), .nonce(nonce_real),
    .tx_serial(tx_real), .busy(busy_real), .overflow(overflow_real), .fifo_count(count_real)
  );

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         abort_byte = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void exp_push(input logic [31:0] v);
    exp_q.push_back(8'hA5);
    exp_q.push_back(v[31:24]);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0]);
  endfunction

  // UART decoder: 4 clocks per bit, samples near the middle of each bit.
  always begin
    logic [7:0] rx;
    logic       b_start, b_stop;
    @(negedge clk);
    if (tx_serial === 1'b0) begin
      start_q.push_back(cyc);
      abort_byte = 1'b0;
      repeat (2) @(negedge clk);
      b_start = tx_serial;
      for (int j = 0; j < 8; j++) begin
        repeat (4) @(negedge clk);
        rx[j] = tx_serial;
      end
      repeat (4) @(negedge clk);
      b_stop = tx_serial;
      if (!abort_byte) begin
        $display("rx byte %02h at cycle %0d", rx, cyc);
        check_val("start_bit", {31'd0, b_start}, 32'd0);
        check_val("stop_bit", {31'd0, b_stop}, 32'd1);
        if (exp_q.size() == 0) check_val("unexpected_byte", {24'd0, rx}, 32'h100);
        else check_val("byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_one(input logic [31:0] v, input bit accepted, output int t);
    @(negedge clk);
    nonce_valid = 1'b1;
    nonce       = v;
    t           = cyc + 1;
    if (accepted) exp_push(v);
    @(negedge clk);
    nonce_valid = 1'b0;
    nonce       = $urandom;
  endtask

  task automatic push_seq(input logic [31:0] v0, input logic [31:0] v1, output int t);
    @(negedge clk);
    nonce_valid = 1'b1;
    nonce       = v0;
    t           = cyc + 1;
    exp_push(v0);
    @(negedge clk);
    nonce = v1;
    exp_push(v1);
    @(negedge clk);
    nonce_valid = 1'b0;
    nonce       = $urandom;
  endtask

  task automatic wait_idle(input int limit, output int t_idle);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check_val("idle_timeout", {31'd0, busy}, 32'd0);
    t_idle = cyc;
  endtask

  task automatic wait_starts(input int n, input int limit);
    int k = 0;
    while (start_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (start_q.size() < n) check_val("start_timeout", start_q.size(), n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_tx", {31'd0, tx_serial}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_count", {29'd0, fifo_count}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          t, t_idle, k;
    logic [31:0] vals [6];

    reset            = 1'b1;
    nonce_valid      = 1'b0;
    nonce            = '0;
    nonce_valid_real = 1'b0;
    nonce_real       = '0;
    repeat (2) @(negedge clk);
    check_val("reset_tx", {31'd0, tx_serial}, 32'd1);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_count", {29'd0, fifo_count}, 32'd0);
    check_val("reset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame: 2-cycle latency, busy falls 241 edges after the push.
    start_q.delete();
    push_one(32'h12345678, 1'b1, t);
    wait_starts(1, 50);
    if (start_q.size() > 0) check_val("latency", start_q[0] - t, 32'd2);
    wait_idle(400, t_idle);
    check_val("busy_drop", t_idle - t, 32'd241);
    repeat (5) @(negedge clk);
    check_val("single_drain", exp_q.size(), 32'd0);
    check_val("single_bytes", start_q.size(), 32'd6);

    // Back-to-back frames separated by one idle cycle.
    start_q.delete();
    push_seq(32'hDEADBEEF, 32'h00000001, t);
    wait_idle(700, t_idle);
    repeat (5) @(negedge clk);
    check_val("b2b_bytes", start_q.size(), 32'd12);
    if (start_q.size() >= 7) begin
      check_val("byte_spacing", start_q[1] - start_q[0], 32'd40);
      check_val("frame_gap", start_q[6] - start_q[0], 32'd241);
    end
    check_val("b2b_drain", exp_q.size(), 32'd0);

    // Overflow: six consecutive pushes, the sixth is dropped.
    start_q.delete();
    vals = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004, 32'h50000005, 32'h66666666};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check_val("ovf_before", {31'd0, overflow}, 32'd0);
        check_val("full_count", {29'd0, fifo_count}, 32'd4);
      end
      nonce_valid = 1'b1;
      nonce       = vals[i];
      if (i < 5) exp_push(vals[i]);
    end
    @(negedge clk);
    nonce_valid = 1'b0;
    check_val("ovf_after", {31'd0, overflow}, 32'd1);
    check_val("ovf_count", {29'd0, fifo_count}, 32'd4);
    wait_idle(1400, t_idle);
    repeat (5) @(negedge clk);
    check_val("ovf_bytes", start_q.size(), 32'd30);
    check_val("ovf_drain", exp_q.size(), 32'd0);
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Push on the pop edge while the FIFO is full.
    pulse_reset();
    start_q.delete();
    @(negedge clk);
    t = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      nonce_valid = 1'b1;
      nonce       = vals[i] ^ 32'h0F0F0F0F;
      exp_push(nonce);
      @(negedge clk);
    end
    nonce_valid = 1'b0;
    check_val("pop_full", {29'd0, fifo_count}, 32'd4);
    while (cyc < t + 241) @(negedge clk);
    nonce_valid = 1'b1;
    nonce       = 32'hA1B2C3D4;
    exp_push(nonce);
    @(negedge clk);
    nonce_valid = 1'b0;
    check_val("pop_push_count", {29'd0, fifo_count}, 32'd4);
    check_val("pop_push_ovf", {31'd0, overflow}, 32'd0);
    wait_idle(1600, t_idle);
    repeat (5) @(negedge clk);
    check_val("pop_push_bytes", start_q.size(), 32'd36);
    check_val("pop_push_drain", exp_q.size(), 32'd0);

    // Mid-frame reset during the data bits of the second byte.
    start_q.delete();
    @(negedge clk);
    nonce_valid = 1'b1;
    nonce       = 32'hCAFEF00D;
    t           = cyc + 1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    nonce = 32'h0BADBEEF;
    @(negedge clk);
    nonce_valid = 1'b0;
    while (cyc < t + 55) @(negedge clk);
    check_val("pre_rst_count", {29'd0, fifo_count}, 32'd1);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset      = 1'b1;
    abort_byte = 1'b1;
    #1;
    check_val("mid_rst_tx", {31'd0, tx_serial}, 32'd1);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_val("after_rst_drain", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (60) @(negedge clk);
    start_q.delete();
    push_one(32'h89ABCDEF, 1'b1, t);
    wait_idle(400, t_idle);
    repeat (5) @(negedge clk);
    check_val("post_rst_bytes", start_q.size(), 32'd6);
    check_val("post_rst_drain", exp_q.size(), 32'd0);

    // Real rate: start bit lasts 1250 clocks.
    @(negedge clk);
    nonce_valid_real = 1'b1;
    nonce_real       = 32'h12345678;
    @(negedge clk);
    nonce_valid_real = 1'b0;
    k = 0;
    while (tx_real !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_val("real_busy", {31'd0, busy_real}, 32'd1);
    k = 0;
    while (tx_real === 1'b0 && k < 3000) begin
      k++;
      @(negedge clk);
    end
    check_val("real_bit_len", k, 32'd1250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
